down_counter: RTL and testbench
===============================

Name: down_counter

Overview:
- Loadable down-counter/timer, WIDTH bits. Counterpart to the team's free-running up-counter.
- Loads a start value, then decrements on each enabled clock.
- Flags terminal count with a one-cycle pulse.
- In one-shot mode it stops at 0; in auto-reload mode it runs periodically.
- Used as an interval timer and delay generator beside the existing counter, in the same clock domain.

Parameters:
- WIDTH, 8, bit width of the count, the load value and the reload register.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- load  in  1  loads load_val into the count and the reload register.
- load_val  in  WIDTH  start/reload value.
- en  in  1  count enable; decrement happens only when en=1.
- auto_reload  in  1  1 = periodic mode, 0 = one-shot; sampled at the terminal cycle.
- out  out  WIDTH  current count, registered.
- zero  out  1  combinational, out==0.
- tc  out  1  terminal-count pulse, registered, one cycle wide.
- busy  out  1  registered; 1 while state is RUN or PAUSE.

Behaviour:
- Reset is synchronous and active-high. It is sampled on the rising edge of clk and overrides every other input.
- Reset values: out=0, reload register=0, tc=0, busy=0, state=IDLE, zero=1.
- State machine states: IDLE, RUN, PAUSE, DONE.
- Priority, highest first: rst, load, count/terminal logic.
- load=1, any state:
  - out<=load_val and reload<=load_val.
  - tc<=0.
  - Next state is RUN if load_val!=0; otherwise IDLE (busy=0, no tc).
  - Latency 1: load_val appears on out on the next edge.
- RUN, en=0: out holds and state goes to PAUSE.
- PAUSE, en=0: out holds.
- PAUSE, en=1: returns to RUN and decrements on that same edge. There is no lost cycle.
- RUN or PAUSE, en=1, out>1: out<=out-1, tc<=0.
- RUN or PAUSE, en=1, out==1 (terminal cycle), auto_reload=0:
  - out<=0, tc<=1, state<=DONE, busy<=0.
- RUN or PAUSE, en=1, out==1 (terminal cycle), auto_reload=1:
  - out<=reload, tc<=1, state stays RUN.
  - Period is reload enabled cycles.
- DONE: out stays 0 and tc returns to 0. Only load or rst leaves DONE. en is ignored.
- IDLE: out holds and en is ignored.
- tc is high exactly on the cycle that out first shows 0 (one-shot) or the reload value (auto-reload). It is never high for two consecutive cycles unless reload==1 in auto-reload mode, where it is high every enabled cycle.
- No wrap-around: out never transitions 0 -> 2^WIDTH-1.
- load during RUN or PAUSE abandons the count without a tc. If load coincides with a terminal cycle, load wins and tc=0.
- rst mid-count: all outputs return to reset values on that edge. rst together with load means rst wins.
- Arithmetic is unsigned WIDTH-bit. load_val=2^WIDTH-1 is legal and gives 255 enabled cycles to tc at WIDTH=8.
- auto_reload may change at any time; only its value on the terminal cycle matters.

Test Plan (all at WIDTH=8):
1. Reset:
   - Stimulus: rst=1 for 2 cycles, then other inputs 0.
   - Required: out=0, zero=1, tc=0, busy=0. out stays 0 for 10 cycles with en=1.
2. One-shot:
   - Stimulus: load 5 for 1 cycle, then en=1 held, auto_reload=0.
   - Required: out=5,4,3,2,1,0 on consecutive cycles.
   - Required: tc=1 only on the cycle out=0; busy falls on that same edge.
   - Required: out stays 0 and tc=0 for the next 20 cycles.
3. Auto-reload:
   - Stimulus: load 3, en=1, auto_reload=1.
   - Required: out=3,2,1,3,2,1,3.
   - Required: tc=1 on each cycle out returns to 3 (every 3rd cycle); busy stays 1.
   - Stimulus: drop auto_reload mid-period.
   - Required: the next terminal goes to 0/DONE.
4. Pause:
   - Stimulus: load 10; en=1 for 3 cycles, 0 for 4 cycles, then 1.
   - Required: out=10,9,8,7, holds 7 for 4 cycles, then 6..0.
   - Required: tc comes 7 enabled cycles after resume; busy stays 1 throughout the pause.
5. Overrides:
   - Stimulus: load 200, count to 150, then load 4.
   - Required: out=4 next cycle with no tc.
   - Stimulus: assert rst and load 9 in the same cycle.
   - Required: out=0, busy=0.
   - Stimulus: load on the terminal cycle (out==1).
   - Required: tc=0, out=load_val.
6. Bounds:
   - Stimulus: load 0.
   - Required: out=0, state IDLE, busy=0, no tc.
   - Stimulus: load 255, en=1.
   - Required: tc after exactly 255 cycles; out never shows 255 after reaching 0.

Source files
------------

// File: rtl/down_counter.sv
// Loadable down-counter/timer with one-shot and auto-reload modes.
// Emits a one-cycle terminal-count pulse when the count expires.
module down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             tc,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] reload_nx;
  logic [WIDTH-1:0] out_nx;
  logic             tc_nx;
  logic             busy_nx;

  always_comb begin
    state_nx  = state;
    out_nx    = out;
    reload_nx = reload;
    tc_nx     = 1'b0;
    if (load) begin
      out_nx    = load_val;
      reload_nx = load_val;
      state_nx  = (load_val != '0) ? RUN : IDLE;
    end else begin
      unique case (state)
        RUN, PAUSE: begin
          if (!en) begin
            state_nx = PAUSE;
          end else if (out > WIDTH'(1)) begin
            out_nx   = out - WIDTH'(1);
            state_nx = RUN;
          end else if (out == WIDTH'(1)) begin
            tc_nx = 1'b1;
            if (auto_reload) begin
              out_nx   = reload;
              state_nx = RUN;
            end else begin
              out_nx   = '0;
              state_nx = DONE;
            end
          end else begin
            // Never reached from a nonzero load; park safely.
            state_nx = DONE;
          end
        end
        IDLE, DONE: begin
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  assign busy_nx = (state_nx == RUN) || (state_nx == PAUSE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      out    <= '0;
      reload <= '0;
      tc     <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nx;
      out    <= out_nx;
      reload <= reload_nx;
      tc     <= tc_nx;
      busy   <= busy_nx;
    end
  end

  assign zero = (out == '0);

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: vector table, directed
// corner sequences and random stimulus against a reference model.
module tb_down_counter;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] load_val;
  logic       en;
  logic       auto_reload;
  logic [7:0] out;
  logic       zero;
  logic       tc;
  logic       busy;

  int passed;
  int total;

  // Reference model: count value, reload value, active flag.
  int m_out;
  int m_reload;
  bit m_tc;
  bit m_active;

  down_counter #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_val    (load_val),
    .en          (en),
    .auto_reload (auto_reload),
    .out         (out),
    .zero        (zero),
    .tc          (tc),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       r;
    bit       l;
    bit [7:0] v;
    bit       e;
    bit       a;
    int       eo;
    bit       etc;
    bit       ebusy;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
  endtask

  function automatic void model(input bit r, input bit l,
                                input int v, input bit e,
                                input bit a);
    m_tc = 1'b0;
    if (r) begin
      m_out    = 0;
      m_reload = 0;
      m_active = 1'b0;
    end else if (l) begin
      m_out    = v;
      m_reload = v;
      m_active = (v != 0);
    end else if (m_active && e) begin
      if (m_out == 1) begin
        m_tc = 1'b1;
        if (a) m_out = m_reload;
        else begin
          m_out    = 0;
          m_active = 1'b0;
        end
      end else begin
        m_out = m_out - 1;
      end
    end
  endfunction

  task automatic step(input bit r, input bit l, input int v,
                      input bit e, input bit a);
    rst         = r;
    load        = l;
    load_val    = v[7:0];
    en          = e;
    auto_reload = a;
    @(posedge clk);
    #1;
    model(r, l, v, e, a);
    chk("model_out", int'(out), m_out);
    chk("model_zero", int'(zero), int'(m_out == 0));
    chk("model_tc", int'(tc), int'(m_tc));
    chk("model_busy", int'(busy), int'(m_active));
  endtask

  function automatic void push(input bit r, input bit l,
                               input int v, input bit e,
                               input bit a, input int eo,
                               input bit etc, input bit eb);
    vec_t t;
    t.r = r; t.l = l; t.v = v[7:0]; t.e = e; t.a = a;
    t.eo = eo; t.etc = etc; t.ebusy = eb;
    tbl.push_back(t);
  endfunction

  int tc_seen;
  int tc_at;

  initial begin
    passed = 0;
    total  = 0;
    m_out = 0; m_reload = 0; m_tc = 0; m_active = 0;
    rst = 1'b1; load = 1'b0; load_val = '0;
    en = 1'b0; auto_reload = 1'b0;

    // Reset, then en held with nothing loaded.
    push(1, 0, 0, 0, 0, 0, 0, 0);
    push(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) push(0, 0, 0, 1, 0, 0, 0, 0);
    // One-shot from 5.
    push(0, 1, 5, 0, 0, 5, 0, 1);
    for (int k = 4; k >= 1; k--) push(0, 0, 0, 1, 0, k, 0, 1);
    push(0, 0, 0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) push(0, 0, 0, 1, 0, 0, 0, 0);
    // Auto-reload from 3, then drop mode mid-period.
    push(0, 1, 3, 1, 1, 3, 0, 1);
    push(0, 0, 0, 1, 1, 2, 0, 1);
    push(0, 0, 0, 1, 1, 1, 0, 1);
    push(0, 0, 0, 1, 1, 3, 1, 1);
    push(0, 0, 0, 1, 1, 2, 0, 1);
    push(0, 0, 0, 1, 1, 1, 0, 1);
    push(0, 0, 0, 1, 1, 3, 1, 1);
    push(0, 0, 0, 1, 0, 2, 0, 1);
    push(0, 0, 0, 1, 0, 1, 0, 1);
    push(0, 0, 0, 1, 0, 0, 1, 0);
    push(0, 0, 0, 1, 1, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].l, int'(tbl[i].v), tbl[i].e, tbl[i].a);
      chk("vec_out", int'(out), tbl[i].eo);
      chk("vec_zero", int'(zero), int'(tbl[i].eo == 0));
      chk("vec_tc", int'(tc), int'(tbl[i].etc));
      chk("vec_busy", int'(busy), int'(tbl[i].ebusy));
    end

    // Pause: 10 -> 7, hold 4 cycles, resume to 0.
    step(0, 1, 10, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    chk("pause_at7", int'(out), 7);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0);
      chk("pause_hold", int'(out), 7);
      chk("pause_busy", int'(busy), 1);
    end
    tc_seen = 0;
    tc_at   = 0;
    for (int i = 1; i <= 7; i++) begin
      step(0, 0, 0, 1, 0);
      if (tc) begin
        tc_seen++;
        tc_at = i;
      end
    end
    chk("pause_tc_cnt", tc_seen, 1);
    chk("pause_tc_at", tc_at, 7);

    // Load 200, count to 150, reload 4 without tc.
    step(0, 1, 200, 0, 0);
    for (int i = 0; i < 50; i++) step(0, 0, 0, 1, 0);
    chk("ovr_150", int'(out), 150);
    step(0, 1, 4, 1, 0);
    chk("ovr_load4", int'(out), 4);
    chk("ovr_load4_tc", int'(tc), 0);
    // rst wins over load.
    step(1, 1, 9, 1, 0);
    chk("rst_load_out", int'(out), 0);
    chk("rst_load_busy", int'(busy), 0);
    // Load on a terminal cycle.
    step(0, 1, 2, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("term_pre", int'(out), 1);
    step(0, 1, 7, 1, 0);
    chk("term_load_out", int'(out), 7);
    chk("term_load_tc", int'(tc), 0);

    // Reload value 1: tc every enabled cycle.
    step(0, 1, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 1);
      chk("rl1_tc", int'(tc), 1);
    end

    // Bounds: load 0, then full-range 255.
    step(0, 1, 0, 1, 0);
    chk("ld0_out", int'(out), 0);
    chk("ld0_busy", int'(busy), 0);
    chk("ld0_tc", int'(tc), 0);
    step(0, 1, 255, 0, 0);
    tc_seen = 0;
    tc_at   = 0;
    for (int i = 1; i <= 255; i++) begin
      step(0, 0, 0, 1, 0);
      if (tc) begin
        tc_seen++;
        tc_at = i;
      end
    end
    chk("max_tc_cnt", tc_seen, 1);
    chk("max_tc_at", tc_at, 255);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 0);
      chk("max_no_wrap", int'(out), 0);
    end

    // Random stimulus against the model.
    for (int i = 0; i < 2000; i++) begin
      bit r;
      bit l;
      int v;
      r = ($urandom_range(0, 99) == 0);
      l = ($urandom_range(0, 99) < 6);
      v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                       : $urandom_range(0, 6);
      step(r, l, v, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 1) == 1));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
